xdma_axis_fifo: RTL and testbench

XDMA_AXIS_FIFO -- requirements
Module: xdma_axis_fifo

---
 rtl/xdma_pkg.sv | 18 +
 rtl/xdma_fifo_ram.sv | 27 ++
 rtl/xdma_axis_fifo.sv | 125 ++++++++++++
 tb/tb_xdma_axis_fifo.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/xdma_pkg.sv
// Shared XDMA definitions: default stream width and the AXI-Stream beat layout
// used by the C2H stream buffering logic.
package xdma_pkg;

    localparam int XDMA_DATA_WIDTH = 512;

    typedef struct packed {
        logic [XDMA_DATA_WIDTH-1:0]   tdata;
        logic [XDMA_DATA_WIDTH/8-1:0] tkeep;
        logic                         tlast;
    } axis_beat_t;

    // Bits needed to store one beat (tdata + tkeep + tlast) at a given width.
    function automatic int beat_width(input int dw);
        return dw + dw / 8 + 1;
    endfunction

endpackage

// File: rtl/xdma_fifo_ram.sv
// Storage array for the XDMA AXI-Stream FIFO: one synchronous write port,
// one asynchronous read port, no reset.
module xdma_fifo_ram #(
    parameter int WIDTH = 577,
    parameter int DEPTH = 16
) (
    input  logic                     clock,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [WIDTH-1:0]         rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // NOTE: the array has no reset on purpose; validity is tracked by the
    // pointers and level, and leaving it unreset lets it map onto plain RAM.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/xdma_axis_fifo.sv
// First-word-fall-through AXI-Stream FIFO between the batch packetizer and the
// XDMA C2H stream. Define CONFIG_XDMA_AXIS_FIFO_PACKET_MODE_EN for store-and-forward.
module xdma_axis_fifo
    import xdma_pkg::*;
#(
    parameter int DATA_WIDTH   = XDMA_DATA_WIDTH,
    parameter int DEPTH        = 16,
    parameter int AFULL_THRESH = 12
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [DATA_WIDTH-1:0]     s_axis_tdata,
    input  logic [DATA_WIDTH/8-1:0]   s_axis_tkeep,
    input  logic                      s_axis_tlast,
    input  logic                      s_axis_tvalid,
    output logic                      s_axis_tready,
    output logic [DATA_WIDTH-1:0]     m_axis_tdata,
    output logic [DATA_WIDTH/8-1:0]   m_axis_tkeep,
    output logic                      m_axis_tlast,
    output logic                      m_axis_tvalid,
    input  logic                      m_axis_tready,
    output logic                      almost_full,
    output logic [$clog2(DEPTH):0]    level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int BW = beat_width(DATA_WIDTH);
    localparam logic [LW-1:0] FULL_LEVEL  = LW'(DEPTH);
    localparam logic [LW-1:0] AFULL_LEVEL = LW'(AFULL_THRESH);

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [LW-1:0] level_nxt;
    logic [BW-1:0] rd_beat;
    logic          push;
    logic          pop;

    // Ready depends only on registered level, never on m_axis_tready.
    assign s_axis_tready = (level != FULL_LEVEL);
    assign push          = s_axis_tvalid && s_axis_tready;
    assign pop           = m_axis_tvalid && m_axis_tready;

    xdma_fifo_ram #(
        .WIDTH (BW),
        .DEPTH (DEPTH)
    ) u_ram (
        .clock   (clock),
        .wr_en   (push),
        .wr_addr (wr_ptr),
        .wr_data ({s_axis_tlast, s_axis_tkeep, s_axis_tdata}),
        .rd_addr (rd_ptr),
        .rd_data (rd_beat)
    );

    assign {m_axis_tlast, m_axis_tkeep, m_axis_tdata} = rd_beat;

    // NOTE: every always_comb output gets a default before any branch so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        level_nxt = level;
        unique case ({push, pop})
            2'b10:   level_nxt = level + 1'b1;
            2'b01:   level_nxt = level - 1'b1;
            default: level_nxt = level;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            level       <= '0;
            almost_full <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            level       <= level_nxt;
            almost_full <= (level_nxt >= AFULL_LEVEL);
        end
    end

`ifdef CONFIG_XDMA_AXIS_FIFO_PACKET_MODE_EN
    logic [LW-1:0] pkt_cnt;
    logic [LW-1:0] pkt_cnt_nxt;
    logic          bypass;
    logic          push_last;
    logic          pop_last;

    assign push_last = push && s_axis_tlast;
    assign pop_last  = pop && m_axis_tlast;

    always_comb begin
        pkt_cnt_nxt = pkt_cnt;
        unique case ({push_last, pop_last})
            2'b10:   pkt_cnt_nxt = pkt_cnt + 1'b1;
            2'b01:   pkt_cnt_nxt = pkt_cnt - 1'b1;
            default: pkt_cnt_nxt = pkt_cnt;
        endcase
    end

    // A full FIFO with no complete packet would never drain; bypass forwards
    // the oversized packet until its tlast leaves.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pkt_cnt <= '0;
            bypass  <= 1'b0;
        end else begin
            pkt_cnt <= pkt_cnt_nxt;
            if (pop_last) begin
                bypass <= 1'b0;
            end else if (level == FULL_LEVEL && pkt_cnt == '0) begin
                bypass <= 1'b1;
            end
        end
    end

    assign m_axis_tvalid = (level != '0) && (pkt_cnt != '0 || bypass);
`else
    assign m_axis_tvalid = (level != '0);
`endif

endmodule

// File: tb/tb_xdma_axis_fifo.sv
// Self-checking bench for xdma_axis_fifo: a reference model plus scoreboard
// queue; packet-mode scenarios build when CONFIG_XDMA_AXIS_FIFO_PACKET_MODE_EN is set.
module tb_xdma_axis_fifo;
    import xdma_pkg::*;

    localparam int DW    = XDMA_DATA_WIDTH;
    localparam int DEPTH = 16;
    localparam int AFULL = 12;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic            clock = 1'b0;
    logic            reset = 1'b1;
    logic [DW-1:0]   s_axis_tdata  = '0;
    logic [DW/8-1:0] s_axis_tkeep  = '0;
    logic            s_axis_tlast  = 1'b0;
    logic            s_axis_tvalid = 1'b0;
    logic            s_axis_tready;
    logic [DW-1:0]   m_axis_tdata;
    logic [DW/8-1:0] m_axis_tkeep;
    logic            m_axis_tlast;
    logic            m_axis_tvalid;
    logic            m_axis_tready = 1'b0;
    logic            almost_full;
    logic [LW-1:0]   level;

    xdma_axis_fifo #(
        .DATA_WIDTH   (DW),
        .DEPTH        (DEPTH),
        .AFULL_THRESH (AFULL)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tkeep  (s_axis_tkeep),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .almost_full   (almost_full),
        .level         (level)
    );

    always #5 clock = ~clock;

    int         checks = 0;
    int         errors = 0;
    axis_beat_t sb[$];
    axis_beat_t cur_beat;
    int         m_level = 0;
    int         m_pkt = 0;
    bit         m_bypass = 1'b0;
    bit         last_push;
    int         pop_count = 0;

    task automatic check(input string tag, input logic [575:0] act, input logic [575:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic axis_beat_t make_beat(input int idx, input bit last);
        axis_beat_t b;
        b.tdata = {16{32'(idx) ^ 32'hA5C3_0000}};
        b.tkeep = {32'(idx * 7 + 1), ~32'(idx)};
        b.tlast = last;
        return b;
    endfunction

    task automatic set_beat(input axis_beat_t b);
        cur_beat     = b;
        s_axis_tdata = b.tdata;
        s_axis_tkeep = b.tkeep;
        s_axis_tlast = b.tlast;
    endtask

    // One clock: compare DUT against the model, score handshakes, advance the model.
    task automatic tick();
        bit         exp_sready;
        bit         exp_mvalid;
        bit         do_push;
        bit         do_pop;
        bit         popped_last;
        axis_beat_t e;
        #1;
        exp_sready = (m_level != DEPTH);
`ifdef CONFIG_XDMA_AXIS_FIFO_PACKET_MODE_EN
        exp_mvalid = (m_level != 0) && (m_pkt != 0 || m_bypass);
        check("bypass", dut.bypass, m_bypass);
`else
        exp_mvalid = (m_level != 0);
`endif
        check("s_ready", s_axis_tready, exp_sready);
        check("m_valid", m_axis_tvalid, exp_mvalid);
        check("level", level, m_level);
        check("almost_full", almost_full, m_level >= AFULL);
        do_push     = s_axis_tvalid && exp_sready;
        do_pop      = m_axis_tready && exp_mvalid;
        popped_last = 1'b0;
        if (do_pop && sb.size() != 0) begin
            e = sb.pop_front();
            check("m_tdata", m_axis_tdata, e.tdata);
            check("m_tkeep", m_axis_tkeep, e.tkeep);
            check("m_tlast", m_axis_tlast, e.tlast);
            popped_last = e.tlast;
            pop_count++;
        end
        if (do_push) sb.push_back(cur_beat);
        last_push = do_push;
        if (popped_last) m_bypass = 1'b0;
        else if (m_level == DEPTH && m_pkt == 0) m_bypass = 1'b1;
        m_pkt   = m_pkt + int'(do_push && cur_beat.tlast) - int'(popped_last);
        m_level = m_level + int'(do_push) - int'(do_pop);
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic push_beat(input axis_beat_t b);
        int n = 0;
        set_beat(b);
        s_axis_tvalid = 1'b1;
        do begin
            tick();
            n++;
        end while (!last_push && n < 100);
        if (!last_push) check("push_timeout", last_push, 1);
        s_axis_tvalid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        s_axis_tvalid = 1'b0;
        m_axis_tready = 1'b1;
        while (m_level != 0 && n < 200) begin
            tick();
            n++;
        end
        check("drain_level", level, 0);
    endtask

    initial begin
        int sent;
        int p0;
        int n;
        repeat (2) @(negedge clock);
        check("rst_level", level, 0);
        check("rst_m_valid", m_axis_tvalid, 0);
        check("rst_s_ready", s_axis_tready, 1);
        check("rst_afull", almost_full, 0);
        reset = 1'b0;
        tick();

        // Three beats held: valid from the cycle after the first push, head stable.
        m_axis_tready = 1'b0;
        for (int i = 0; i < 3; i++) push_beat(make_beat(i, 1'b1));
        check("hold_level", level, 3);
        check("hold_valid", m_axis_tvalid, 1);
        check("hold_head", m_axis_tdata, make_beat(0, 1'b1).tdata);
        tick();
        check("hold_head_stable", m_axis_tdata, make_beat(0, 1'b1).tdata);
        drain();

        // Fill to full, then pop while offering a push that must be refused.
        m_axis_tready = 1'b0;
        for (int i = 0; i < DEPTH; i++) push_beat(make_beat(20 + i, 1'b1));
        check("full_s_ready", s_axis_tready, 0);
        check("full_afull", almost_full, 1);
        set_beat(make_beat(50, 1'b1));
        s_axis_tvalid = 1'b1;
        m_axis_tready = 1'b1;
        tick();
        check("full_pop_level", level, 15);
        check("full_pop_ready", s_axis_tready, 1);
        tick();
        drain();

        // Random ready on both sides across several pointer wraps.
        sent = 0;
        p0   = pop_count;
        n    = 0;
        while ((sent < 40 || pop_count - p0 < 40) && n < 3000) begin
            set_beat(make_beat(100 + sent, 1'b1));
            s_axis_tvalid = (sent < 40) ? 1'($urandom_range(0, 1)) : 1'b0;
            m_axis_tready = 1'($urandom_range(0, 1));
            tick();
            if (last_push) sent++;
            n++;
        end
        check("stream_pops", pop_count - p0, 40);
        drain();

`ifdef CONFIG_XDMA_AXIS_FIFO_PACKET_MODE_EN
        // Store-and-forward: nothing presented until the tlast beat lands.
        m_axis_tready = 1'b1;
        p0 = pop_count;
        for (int i = 0; i < 5; i++) push_beat(make_beat(200 + i, 1'b0));
        check("pkt_wait_valid", m_axis_tvalid, 0);
        push_beat(make_beat(205, 1'b1));
        check("pkt_valid", m_axis_tvalid, 1);
        drain();
        check("pkt_drain_count", pop_count - p0, 6);

        // Oversized packet: full without tlast forces bypass until a tlast pops.
        m_axis_tready = 1'b0;
        for (int i = 0; i < DEPTH; i++) push_beat(make_beat(300 + i, 1'b0));
        check("ovr_valid", m_axis_tvalid, 0);
        m_axis_tready = 1'b1;
        p0 = pop_count;
        n  = 0;
        while (pop_count - p0 < 4 && n < 50) begin
            tick();
            n++;
        end
        check("ovr_bypass", dut.bypass, 1);
        push_beat(make_beat(316, 1'b1));
        drain();
        check("ovr_bypass_clear", dut.bypass, 0);
`endif

        // Reset with a partial packet buffered discards everything.
        m_axis_tready = 1'b0;
        for (int i = 0; i < 7; i++) push_beat(make_beat(400 + i, 1'b0));
        check("pre_rst_level", level, 7);
        reset = 1'b1;
        #2;
        check("mid_rst_level", level, 0);
        check("mid_rst_m_valid", m_axis_tvalid, 0);
        check("mid_rst_s_ready", s_axis_tready, 1);
        sb.delete();
        m_level  = 0;
        m_pkt    = 0;
        m_bypass = 1'b0;
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        m_axis_tready = 1'b1;
        repeat (3) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
